// File: rtl/guess_checker_pkg.sv
// guess_checker_pkg: state encoding, digit constants and BCD helpers shared by the guess checker
package guess_checker_pkg;
   typedef enum logic [2:0] {IDLE, GEN, SHOW, WAIT_ENTRY, CHECK, RESULT, GAME_OVER} state_t;
   localparam int DIGIT_W = 4;
   localparam int NUM_DIGITS = 4;
   localparam logic [DIGIT_W-1:0] EMPTY_DIGIT = 4'hF;
   localparam logic [15:0] LFSR_POLY = 16'hB400;
   // folds each raw nibble into 0-9 so the target is always a valid keypad digit
   function automatic logic [15:0] to_digits(input logic [15:0] raw);
      logic [15:0] d;
      d = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         d[i*DIGIT_W +: DIGIT_W] = (raw[i*DIGIT_W +: DIGIT_W] > 4'd9) ? raw[i*DIGIT_W +: DIGIT_W] - 4'd10
                                                                    : raw[i*DIGIT_W +: DIGIT_W];
      return d;
   endfunction
   // an empty entry nibble never matches, even against a hypothetical F target
   function automatic logic [NUM_DIGITS-1:0] match_digits(input logic [15:0] entry, input logic [15:0] target);
      logic [NUM_DIGITS-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         m[i] = entry[i*DIGIT_W +: DIGIT_W] == target[i*DIGIT_W +: DIGIT_W] && entry[i*DIGIT_W +: DIGIT_W] != EMPTY_DIGIT;
      return m;
   endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR (poly 0xB400), loaded with SEED on reset
//   clk, rst : clock, synchronous active-high reset
//   q        : current LFSR state
module lfsr16
   import guess_checker_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] q
);
   always_ff @(posedge clk)
      if (rst) q <= SEED;
      else q <= (q >> 1) ^ (q[0] ? LFSR_POLY : 16'h0000);
endmodule

// File: rtl/guess_checker.sv
// guess_checker: game-round controller that shows a random 4-digit target and scores the keypad entry
//   clk, rst      : clock, synchronous active-high reset
//   start         : begins a game from IDLE or GAME_OVER
//   entry_value   : four BCD digits from the entry stage, 4'hF = empty
//   entry_ready   : entry stage holds four digits
//   entry_clr     : clears the entry stage (during SHOW and in CHECK)
//   target_digits : current target, show_target: target display enable
//   digit_match   : per-digit match of the last entry, round_pass/round_fail: one-cycle result pulses
//   score, lives, game_over : game status
// Optional: define GUESS_CHECKER_TIMEOUT_EN to fail a round after ENTRY_TIMEOUT cycles without entry.
module guess_checker
   import guess_checker_pkg::*;
#(
   parameter int          SHOW_CYCLES   = 400,
   parameter int          RESULT_CYCLES = 200,
   parameter int          START_LIVES   = 3,
   parameter logic [15:0] SEED          = 16'hACE1,
   parameter int          ENTRY_TIMEOUT = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] entry_value,
   input  logic        entry_ready,
   output logic        entry_clr,
   output logic [15:0] target_digits,
   output logic        show_target,
   output logic [3:0]  digit_match,
   output logic        round_pass,
   output logic        round_fail,
   output logic [7:0]  score,
   output logic [1:0]  lives,
   output logic        game_over
);
`ifdef GUESS_CHECKER_TIMEOUT_EN
   localparam int CNT_MAX = (SHOW_CYCLES > RESULT_CYCLES) ? ((SHOW_CYCLES > ENTRY_TIMEOUT) ? SHOW_CYCLES : ENTRY_TIMEOUT)
                                                          : ((RESULT_CYCLES > ENTRY_TIMEOUT) ? RESULT_CYCLES : ENTRY_TIMEOUT);
`else
   localparam int CNT_MAX = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);
   if (SEED == 16'h0000 || START_LIVES < 1 || START_LIVES > 3 || ENTRY_TIMEOUT < 1) begin : g_bad_param
      $error("guess_checker: invalid parameter");
   end
   state_t state, next;
   logic [15:0] lfsr_q, entry_q;
   logic [CNT_W-1:0] cnt;
   logic show_done, result_done, timeout;
   logic [3:0] match;
   lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk(clk),
      .rst(rst),
      .q  (lfsr_q)
   );
   assign show_done   = cnt == CNT_W'(SHOW_CYCLES - 1);
   assign result_done = cnt == CNT_W'(RESULT_CYCLES - 1);
`ifdef GUESS_CHECKER_TIMEOUT_EN
   assign timeout = state == WAIT_ENTRY && cnt == CNT_W'(ENTRY_TIMEOUT - 1);
`else
   assign timeout = 1'b0;
`endif
   assign match       = match_digits(entry_q, target_digits);
   assign show_target = state == SHOW;
   assign entry_clr   = state == SHOW || state == CHECK;
   assign game_over   = state == GAME_OVER;
   always_comb begin
      next = state;
      case (state)
         IDLE:       if (start) next = GEN;
         GEN:        next = SHOW;
         SHOW:       if (show_done) next = WAIT_ENTRY;
         WAIT_ENTRY: if (entry_ready || timeout) next = CHECK;
         CHECK:      next = RESULT;
         RESULT:     if (result_done) next = (lives == 2'd0) ? GAME_OVER : GEN;
         GAME_OVER:  if (start) next = GEN;
         default:    next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         target_digits <= '0;
         entry_q       <= '0;
         digit_match   <= '0;
         round_pass    <= 1'b0;
         round_fail    <= 1'b0;
         score         <= '0;
         lives         <= 2'(START_LIVES);
      end else begin
         state      <= next;
         // counter restarts on every state change so each timed state counts from zero
         cnt        <= (next != state) ? '0 : cnt + 1'b1;
         round_pass <= 1'b0;
         round_fail <= 1'b0;
         if (start && (state == IDLE || state == GAME_OVER)) begin
            score <= '0;
            lives <= 2'(START_LIVES);
         end
         if (state == GEN) target_digits <= to_digits(lfsr_q);
         // a real entry wins over a coinciding timeout
         if (state == WAIT_ENTRY) entry_q <= entry_ready ? entry_value : {NUM_DIGITS{EMPTY_DIGIT}};
         if (state == CHECK) begin
            digit_match <= match;
            round_pass  <= &match;
            round_fail  <= ~&match;
            if (&match) score <= (score == 8'hFF) ? score : score + 8'd1;
            else lives <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
         end
      end
   end
endmodule

// File: tb/tb_guess_checker.sv
// tb_guess_checker: randomized scoreboard bench for guess_checker against a behavioural game model
module tb_guess_checker;
   localparam logic [15:0] SEED = 16'hACE1;
   typedef struct {
      logic [3:0] dm;
      bit         pass;
      int         score;
      int         lives;
      int         cyc;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, entry_ready = 1'b0;
   logic [15:0] entry_value = 16'hFFFF;
   logic        entry_clr, show_target, round_pass, round_fail, game_over;
   logic [15:0] target_digits;
   logic [3:0]  digit_match;
   logic [7:0]  score;
   logic [1:0]  lives;
   int checks = 0, errors = 0, cyc = 0;
   int score_m = 0, lives_m = 3, next_show = -1, go_cyc = 0;
   logic [15:0] m_lfsr, m_prev, last_t, c_raw;
   logic [3:0]  last_dm;
   exp_t q[$];
   exp_t e;
   bit prev_pulse = 0, prev_show = 0;

   guess_checker #(.SHOW_CYCLES(4), .RESULT_CYCLES(3), .START_LIVES(3), .SEED(SEED), .ENTRY_TIMEOUT(2000)) dut (
      .clk(clk), .rst(rst), .start(start), .entry_value(entry_value), .entry_ready(entry_ready),
      .entry_clr(entry_clr), .target_digits(target_digits), .show_target(show_target),
      .digit_match(digit_match), .round_pass(round_pass), .round_fail(round_fail),
      .score(score), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction
   function automatic logic [15:0] conv(input logic [15:0] raw);
      logic [15:0] r;
      for (int i = 0; i < 4; i++) begin
         int n;
         n = int'(raw[4*i +: 4]);
         r[4*i +: 4] = 4'(n > 9 ? n - 10 : n);
      end
      return r;
   endfunction
   function automatic logic [3:0] ref_match(input logic [15:0] en, input logic [15:0] t);
      logic [3:0] m;
      for (int i = 0; i < 4; i++) m[i] = (en[4*i +: 4] != 4'hF) && (en[4*i +: 4] == t[4*i +: 4]);
      return m;
   endfunction
   function automatic bit has_c(input logic [15:0] v);
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] == 4'hC) return 1;
      return 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask
   task automatic check_reset(input string tag);
      chk({tag, "_target"}, target_digits, 0);
      chk({tag, "_show"}, show_target, 0);
      chk({tag, "_dm"}, digit_match, 0);
      chk({tag, "_pass"}, round_pass, 0);
      chk({tag, "_fail"}, round_fail, 0);
      chk({tag, "_clr"}, entry_clr, 0);
      chk({tag, "_score"}, score, 0);
      chk({tag, "_lives"}, lives, 3);
      chk({tag, "_gameover"}, game_over, 0);
   endtask

   // reference LFSR and cycle counter, running in step with the DUT clock
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      m_prev <= m_lfsr;
      m_lfsr <= rst ? SEED : step(m_lfsr);
   end

   // monitor: target on display entry, round results against the scoreboard queue
   always @(negedge clk) begin
      if (rst) begin
         prev_pulse = 0;
         prev_show  = 0;
      end else begin
         if (show_target && !prev_show) chk("target", target_digits, conv(m_prev));
         if (round_pass || round_fail) begin
            chk("pulse_width", {31'b0, prev_pulse}, 0);
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: pass=%0b fail=%0b expected none", round_pass, round_fail);
            end else begin
               e = q.pop_front();
               chk("digit_match", digit_match, e.dm);
               chk("round_pass", round_pass, e.pass);
               chk("round_fail", round_fail, !e.pass);
               chk("score", score, e.score);
               chk("lives", lives, e.lives);
               chk("latency", cyc, e.cyc);
            end
         end
         prev_pulse = round_pass || round_fail;
         prev_show  = show_target;
      end
   end

   task automatic do_round(input int mode, input bit poke);
      logic [15:0] t, en;
      logic [3:0]  em;
      int n, c;
      n = 0;
      while (!show_target && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!show_target) begin
         chk("show_timeout", {31'b0, show_target}, 1);
         finish_run();
      end
      if (next_show >= 0) chk("result_hold", cyc, next_show);
      t = conv(m_prev);
      n = 0;
      while (show_target && n < 20) begin
         chk("clr_in_show", entry_clr, 1);
         if (poke) begin
            entry_value = t;
            entry_ready = n < 3;
         end
         n++;
         @(negedge clk);
      end
      chk("show_len", n, 4);
      chk("clr_wait", entry_clr, 0);
      if (poke) begin
         entry_ready = 0;
         repeat (3) @(negedge clk);
         chk("still_waiting", entry_clr, 0);
      end
      en = t;
      if (mode == 1) en[7:4] = 4'((int'(t[7:4]) + 1) % 10);
      if (mode == 2) en = {12'hFFF, t[3:0]};
      if (mode >= 3) for (int i = 0; i < 4; i++) en[4*i +: 4] = 4'($urandom_range(0, 9));
      if (mode == 4 && en == t) en[3:0] = 4'((int'(t[3:0]) + 1) % 10);
      em = ref_match(en, t);
      if (em == 4'hF) score_m = (score_m < 255) ? score_m + 1 : 255;
      else lives_m = (lives_m > 0) ? lives_m - 1 : 0;
      c = cyc;
      q.push_back('{dm: em, pass: em == 4'hF, score: score_m, lives: lives_m, cyc: c + 2});
      last_t  = t;
      last_dm = em;
      entry_value = en;
      entry_ready = 1;
      @(negedge clk);
      chk("clr_check", entry_clr, 1);
      entry_ready = 0;
      entry_value = 16'hFFFF;
      n = 0;
      while (q.size() != 0 && n < 6) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("result_timeout", q.size(), 0);
         finish_run();
      end
      next_show = (lives_m == 0) ? -1 : c + 6;
      go_cyc    = c + 5;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset("rst");
      rst = 0;
      entry_value = 16'h0000;
      entry_ready = 1;
      repeat (3) @(negedge clk);
      chk("idle_ignores_entry", show_target, 0);
      entry_ready = 0;
      n = 0;
      while (!has_c(step(m_lfsr)) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      c_raw = step(m_lfsr);
      start = 1;
      @(negedge clk);
      start = 0;
      do_round(0, 1);
      for (int i = 0; i < 4; i++)
         if (c_raw[4*i +: 4] == 4'hC) chk("nibble_c_to_2", target_digits[4*i +: 4], 2);
      do_round(1, 0);
      do_round(2, 0);
      do_round(4, 0);
      n = 0;
      while (!game_over && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("game_over", game_over, 1);
      chk("game_over_time", cyc, go_cyc);
      chk("go_score", score, score_m);
      chk("go_lives", lives, 0);
      chk("go_target", target_digits, last_t);
      chk("go_dm", digit_match, last_dm);
      entry_value = last_t;
      entry_ready = 1;
      repeat (3) @(negedge clk);
      entry_ready = 0;
      chk("go_held", game_over, 1);
      start = 1;
      @(negedge clk);
      start = 0;
      score_m = 0;
      lives_m = 3;
      next_show = -1;
      chk("restart_score", score, 0);
      chk("restart_lives", lives, 3);
      chk("restart_go", game_over, 0);
      do_round(3, 0);
      do_round(0, 0);
      do_round(0, 0);
      do_round(3, 0);
      do_round(0, 0);
      rst = 1;
      @(negedge clk);
      check_reset("mid_rst");
      rst = 0;
      score_m = 0;
      lives_m = 3;
      next_show = -1;
      start = 1;
      @(negedge clk);
      start = 0;
      do_round(0, 0);
      do_round(4, 0);
      repeat (5) @(negedge clk);
      finish_run();
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
